// File: rtl/fence_board_if.sv
// rtl/fence_board_if.sv - request/response, counter status and fence handshake bundle for fence_board
interface fence_board_if #(
    parameter int NUM_WARP = 8,
    parameter int WID_W    = $clog2(NUM_WARP)
);
    logic                req_valid;
    logic [WID_W-1:0]    req_wid;
    logic                rsp_valid;
    logic [WID_W-1:0]    rsp_wid;
    logic [NUM_WARP-1:0] full;
    logic [NUM_WARP-1:0] empty;
    logic                fence_valid;
    logic [WID_W-1:0]    fence_wid;
    logic                fence_ready;
    logic [NUM_WARP-1:0] fence_busy;
    logic                done_valid;
    logic [WID_W-1:0]    done_wid;
    logic                done_ready;

    modport master (
        output req_valid, req_wid, rsp_valid, rsp_wid,
        output fence_valid, fence_wid, done_ready,
        input  full, empty, fence_ready, fence_busy, done_valid, done_wid
    );

    modport slave (
        input  req_valid, req_wid, rsp_valid, rsp_wid,
        input  fence_valid, fence_wid, done_ready,
        output full, empty, fence_ready, fence_busy, done_valid, done_wid
    );
endinterface

// File: rtl/fence_board.sv
// rtl/fence_board.sv - per-warp outstanding-request counters with a single-fence sequencer
// Optional sticky illegal-event flag err when FENCE_BOARD_ERR_EN is defined.
module fence_board #(
    parameter int NUM_WARP = 8,
    parameter int DEPTH    = 4,
    parameter int WID_W    = $clog2(NUM_WARP),
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
`ifdef FENCE_BOARD_ERR_EN
    output logic err,
`endif
    fence_board_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    logic [CNT_W-1:0]    count [NUM_WARP];
    logic [NUM_WARP-1:0] full_v;
    logic [NUM_WARP-1:0] empty_v;
    logic                req_acc;
    logic                rsp_acc;

    state_t              state;
    logic [WID_W-1:0]    wid_q;
    logic                fence_ready_q;
    logic [NUM_WARP-1:0] busy_q;
    logic                done_valid_q;
    logic [WID_W-1:0]    done_wid_q;

    always_comb begin
        full_v  = '0;
        empty_v = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            full_v[w]  = (count[w] == CNT_W'(DEPTH));
            empty_v[w] = (count[w] == '0);
        end
    end

    assign req_acc = bus.req_valid & ~full_v[bus.req_wid];
    assign rsp_acc = bus.rsp_valid & ~empty_v[bus.rsp_wid];

    // A request and response hitting the same warp in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                count[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARP; w++) begin
                if (req_acc && (bus.req_wid == WID_W'(w)) &&
                    !(rsp_acc && (bus.rsp_wid == WID_W'(w)))) begin
                    count[w] <= count[w] + 1'b1;
                end else if (rsp_acc && (bus.rsp_wid == WID_W'(w)) &&
                             !(req_acc && (bus.req_wid == WID_W'(w)))) begin
                    count[w] <= count[w] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wid_q         <= '0;
            fence_ready_q <= 1'b1;
            busy_q        <= '0;
            done_valid_q  <= 1'b0;
            done_wid_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.fence_valid) begin
                        state         <= S_WAIT;
                        wid_q         <= bus.fence_wid;
                        fence_ready_q <= 1'b0;
                        busy_q        <= NUM_WARP'(1) << bus.fence_wid;
                    end
                end
                S_WAIT: begin
                    // Requests still arriving for wid_q keep us here until they drain.
                    if (empty_v[wid_q]) begin
                        state        <= S_DONE;
                        done_valid_q <= 1'b1;
                        done_wid_q   <= wid_q;
                    end
                end
                S_DONE: begin
                    if (bus.done_ready) begin
                        state         <= S_IDLE;
                        done_valid_q  <= 1'b0;
                        fence_ready_q <= 1'b1;
                        busy_q        <= '0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    done_valid_q  <= 1'b0;
                    fence_ready_q <= 1'b1;
                    busy_q        <= '0;
                end
            endcase
        end
    end

`ifdef FENCE_BOARD_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((bus.req_valid && full_v[bus.req_wid]) ||
                     (bus.rsp_valid && empty_v[bus.rsp_wid])) begin
            err <= 1'b1;
        end
    end
`endif

    assign bus.full        = full_v;
    assign bus.empty       = empty_v;
    assign bus.fence_ready = fence_ready_q;
    assign bus.fence_busy  = busy_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_wid    = done_wid_q;

endmodule
